// File: rtl/wb_regfile_stage.sv
// Writeback stage of the 16-bit core: picks the writeback value, commits it to the
// register file and N/V/Z flags, latches HALT, and serves decode reads with bypass.
module wb_regfile_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_mem_to_reg,
  input  logic              in_write_reg,
  input  logic              in_pcs,
  input  logic [ADDR_W-1:0] in_dst_reg,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_nxt,
  input  logic              in_halt,
  input  logic [2:0]        in_flag,
  input  logic [2:0]        in_flag_en,
  input  logic [ADDR_W-1:0] in_rd_addr1,
  input  logic [ADDR_W-1:0] in_rd_addr2,
  output logic [DATA_W-1:0] out_rd_data1,
  output logic [DATA_W-1:0] out_rd_data2,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [ADDR_W-1:0] out_wb_dst,
  output logic              out_wb_en,
  output logic [2:0]        out_flag,
  output logic [2:0]        out_flag_fwd,
  output logic              out_halted,
  output logic [CNT_W-1:0]  out_commit_cnt
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs;

  assign out_wb_data = in_pcs ? in_pc_nxt : (in_mem_to_reg ? in_mem_data : in_alu_out);
  assign out_wb_dst  = in_dst_reg;
  assign out_wb_en   = in_write_reg & ~out_halted & (in_dst_reg != '0);

  // R0 is never enabled by out_wb_en, so its entry stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (out_wb_en && in_dst_reg == ADDR_W'(i)) regs[i] <= out_wb_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] addr);
    if (addr == '0)                          return '0;
    else if (out_wb_en && addr == in_dst_reg) return out_wb_data;
    else                                      return regs[addr];
  endfunction

  assign out_rd_data1 = rd_port(in_rd_addr1);
  assign out_rd_data2 = rd_port(in_rd_addr2);

  // Merged flag view; once halted it collapses to the held value, so it also
  // serves as the next-state for the flag register.
  assign out_flag_fwd = (in_flag_en & {3{~out_halted}} & in_flag) |
                        (~(in_flag_en & {3{~out_halted}}) & out_flag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flag       <= '0;
      out_halted     <= 1'b0;
      out_commit_cnt <= '0;
    end else begin
      out_flag <= out_flag_fwd;
      if (in_halt) out_halted <= 1'b1;
      if (out_wb_en) out_commit_cnt <= out_commit_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: bypass, writeback select, R0, flags, halt, reset.
module tb_wb_regfile_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_mem_to_reg = 0, in_write_reg = 0, in_pcs = 0, in_halt = 0;
  logic [3:0]  in_dst_reg = 0, in_rd_addr1 = 0, in_rd_addr2 = 0;
  logic [15:0] in_alu_out = 0, in_mem_data = 0, in_pc_nxt = 0;
  logic [2:0]  in_flag = 0, in_flag_en = 0;
  logic [15:0] out_rd_data1, out_rd_data2, out_wb_data, out_commit_cnt;
  logic [3:0]  out_wb_dst;
  logic        out_wb_en, out_halted;
  logic [2:0]  out_flag, out_flag_fwd;

  int n_checks = 0;
  int n_fail   = 0;

  wb_regfile_stage dut (
    .clk(clk), .rst(rst),
    .in_mem_to_reg(in_mem_to_reg), .in_write_reg(in_write_reg), .in_pcs(in_pcs),
    .in_dst_reg(in_dst_reg), .in_alu_out(in_alu_out), .in_mem_data(in_mem_data),
    .in_pc_nxt(in_pc_nxt), .in_halt(in_halt), .in_flag(in_flag), .in_flag_en(in_flag_en),
    .in_rd_addr1(in_rd_addr1), .in_rd_addr2(in_rd_addr2),
    .out_rd_data1(out_rd_data1), .out_rd_data2(out_rd_data2),
    .out_wb_data(out_wb_data), .out_wb_dst(out_wb_dst), .out_wb_en(out_wb_en),
    .out_flag(out_flag), .out_flag_fwd(out_flag_fwd), .out_halted(out_halted),
    .out_commit_cnt(out_commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst = 1'b0;
    #1;
    for (int a = 0; a < 16; a++) begin
      in_rd_addr1 = 4'(a);
      in_rd_addr2 = 4'(15 - a);
      #1;
      check($sformatf("reset_rd1_%0d", a), 32'(out_rd_data1), 32'h0);
      check($sformatf("reset_rd2_%0d", 15 - a), 32'(out_rd_data2), 32'h0);
    end
    check("reset_flag", 32'(out_flag), 32'h0);
    check("reset_halted", 32'(out_halted), 32'h0);
    check("reset_cnt", 32'(out_commit_cnt), 32'h0);

    // bypass on the write cycle, then architectural read
    tick();
    in_write_reg = 1; in_dst_reg = 3; in_alu_out = 16'hABCD; in_rd_addr1 = 3; in_rd_addr2 = 4;
    #1;
    check("bypass_rd1", 32'(out_rd_data1), 32'hABCD);
    check("bypass_rd2_other", 32'(out_rd_data2), 32'h0);
    check("bypass_wb_en", 32'(out_wb_en), 32'h1);
    check("bypass_wb_dst", 32'(out_wb_dst), 32'h3);
    tick();
    in_write_reg = 0;
    #1;
    check("reg3_after", 32'(out_rd_data1), 32'hABCD);
    check("cnt_1", 32'(out_commit_cnt), 32'h1);

    // mem data select
    in_write_reg = 1; in_mem_to_reg = 1; in_mem_data = 16'h1234; in_alu_out = 16'hDEAD;
    in_dst_reg = 5;
    #1;
    check("memsel_wb_data", 32'(out_wb_data), 32'h1234);
    tick();
    in_write_reg = 0; in_rd_addr2 = 5;
    #1;
    check("reg5_mem", 32'(out_rd_data2), 32'h1234);
    check("cnt_2", 32'(out_commit_cnt), 32'h2);

    // PCS has priority over mem_to_reg
    in_write_reg = 1; in_pcs = 1; in_pc_nxt = 16'h0042;
    #1;
    check("pcs_wb_data", 32'(out_wb_data), 32'h0042);
    tick();
    in_write_reg = 0; in_pcs = 0; in_mem_to_reg = 0;
    #1;
    check("reg5_pcs", 32'(out_rd_data2), 32'h0042);
    check("cnt_3", 32'(out_commit_cnt), 32'h3);

    // write to R0 discarded
    in_write_reg = 1; in_dst_reg = 0; in_alu_out = 16'hFFFF; in_rd_addr1 = 0;
    #1;
    check("r0_wb_en", 32'(out_wb_en), 32'h0);
    check("r0_bypass", 32'(out_rd_data1), 32'h0);
    tick();
    check("r0_after", 32'(out_rd_data1), 32'h0);
    check("r0_cnt", 32'(out_commit_cnt), 32'h3);

    // both ports bypass together
    in_dst_reg = 7; in_alu_out = 16'h5A5A; in_rd_addr1 = 7; in_rd_addr2 = 7;
    #1;
    check("dual_bypass_rd1", 32'(out_rd_data1), 32'h5A5A);
    check("dual_bypass_rd2", 32'(out_rd_data2), 32'h5A5A);
    tick();
    in_write_reg = 0;
    #1;
    check("cnt_4", 32'(out_commit_cnt), 32'h4);

    // per-bit flag update
    in_flag = 3'b111; in_flag_en = 3'b001;
    #1;
    check("flag_fwd_1", 32'(out_flag_fwd), 32'h1);
    check("flag_hold_1", 32'(out_flag), 32'h0);
    tick();
    check("flag_1", 32'(out_flag), 32'h1);
    in_flag = 3'b010; in_flag_en = 3'b110;
    #1;
    check("flag_fwd_2", 32'(out_flag_fwd), 32'h3);
    tick();
    check("flag_2", 32'(out_flag), 32'h3);
    in_flag_en = 0;

    // HLT cycle still commits its own write
    in_halt = 1; in_write_reg = 1; in_dst_reg = 2; in_alu_out = 16'h0007; in_rd_addr1 = 2;
    tick();
    in_halt = 0;
    #1;
    check("halted_set", 32'(out_halted), 32'h1);
    check("halt_reg2", 32'(out_rd_data1), 32'h0007);
    check("halt_cnt", 32'(out_commit_cnt), 32'h5);

    // everything suppressed after halt
    in_alu_out = 16'h0008; in_flag = 3'b100; in_flag_en = 3'b111;
    #1;
    check("halted_wb_en", 32'(out_wb_en), 32'h0);
    check("halted_no_bypass", 32'(out_rd_data1), 32'h0007);
    check("halted_flag_fwd", 32'(out_flag_fwd), 32'h3);
    tick();
    check("halted_reg2", 32'(out_rd_data1), 32'h0007);
    check("halted_flag", 32'(out_flag), 32'h3);
    check("halted_cnt", 32'(out_commit_cnt), 32'h5);
    check("halted_sticky", 32'(out_halted), 32'h1);

    // asynchronous reset mid-cycle
    in_write_reg = 0; in_flag_en = 0;
    rst = 1;
    #1;
    check("arst_flag", 32'(out_flag), 32'h0);
    check("arst_halted", 32'(out_halted), 32'h0);
    check("arst_cnt", 32'(out_commit_cnt), 32'h0);
    check("arst_reg2", 32'(out_rd_data1), 32'h0);
    in_rd_addr2 = 3;
    #1;
    check("arst_reg3", 32'(out_rd_data2), 32'h0);

    // write during reset is lost
    in_write_reg = 1; in_dst_reg = 4; in_alu_out = 16'h1111; in_rd_addr1 = 4;
    tick();
    in_write_reg = 0;
    #2 rst = 0;
    #1;
    check("rst_write_lost", 32'(out_rd_data1), 32'h0);
    check("rst_write_cnt", 32'(out_commit_cnt), 32'h0);

    // normal operation resumes
    in_write_reg = 1; in_alu_out = 16'h2222;
    tick();
    in_write_reg = 0;
    #1;
    check("resume_reg4", 32'(out_rd_data1), 32'h2222);
    check("resume_cnt", 32'(out_commit_cnt), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_regfile_stage.md
Name: wb_regfile_stage

Overview:
- Consumer end of the MEM/WB pipeline register: performs writeback for the 16-bit pipelined core.
- Selects the writeback value and commits it to the 16-entry register file.
- Updates the N/V/Z flag register per-bit and latches HALT.
- Serves the two decode-stage read ports with same-cycle write-through bypass, so decode sees a value in the cycle it is being written.

Parameters:
- DATA_W, 16, datapath and register width
- ADDR_W, 4, register address width (2**ADDR_W registers)
- CNT_W, 16, width of commit counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_mem_to_reg  in  1  select mem data for writeback
- in_write_reg  in  1  register write request
- in_pcs  in  1  PCS instruction; write in_pc_nxt
- in_dst_reg  in  ADDR_W  destination register
- in_alu_out  in  DATA_W  ALU result
- in_mem_data  in  DATA_W  load data
- in_pc_nxt  in  DATA_W  PC+2 of retiring instruction
- in_halt  in  1  retiring instruction is HLT
- in_flag  in  3  new flags {N,V,Z}
- in_flag_en  in  3  per-bit flag update enable {N,V,Z}
- in_rd_addr1  in  ADDR_W  decode read port 1 address
- in_rd_addr2  in  ADDR_W  decode read port 2 address
- out_rd_data1  out  DATA_W  read port 1 data (bypassed)
- out_rd_data2  out  DATA_W  read port 2 data (bypassed)
- out_wb_data  out  DATA_W  selected writeback value (forwarding source)
- out_wb_dst  out  ADDR_W  = in_dst_reg
- out_wb_en  out  1  effective write enable this cycle
- out_flag  out  3  registered flags {N,V,Z}
- out_flag_fwd  out  3  flags with this cycle's update merged
- out_halted  out  1  sticky halt
- out_commit_cnt  out  CNT_W  count of committed register writes

Behaviour:
- Writeback select (combinational):
  - out_wb_data = in_pcs ? in_pc_nxt : (in_mem_to_reg ? in_mem_data : in_alu_out).
  - in_pcs has priority over in_mem_to_reg.
- Effective enable: out_wb_en = in_write_reg & ~out_halted & (in_dst_reg != 0).
  - R0 reads 0 always; writes to R0 are discarded and are not counted.
- Register write: on rising clk with out_wb_en=1, reg[in_dst_reg] <= out_wb_data. One write per cycle.
- Reads: combinational.
  - Addr 0 -> 0.
  - Else if out_wb_en and addr == in_dst_reg -> out_wb_data (bypass).
  - Else reg[addr].
  - Both ports are independent; both may bypass in the same cycle.
- Flags: on rising clk, if ~out_halted, each bit i with in_flag_en[i]=1 loads in_flag[i]; bits with enable 0 hold.
  - out_flag_fwd[i] = (in_flag_en[i] & ~out_halted) ? in_flag[i] : out_flag[i].
- Halt:
  - in_halt=1 at a rising edge sets out_halted (sticky until rst).
  - The HLT cycle's own write and flag update still commit if requested.
  - From the next cycle on, all writes, flag updates and counting are suppressed; reads continue to work.
- Commit counter: increments by 1 on each rising edge with out_wb_en=1; wraps from 2**CNT_W-1 to 0.
- Reset (async, any time, including mid-write):
  - All registers, out_flag, out_halted and out_commit_cnt go to 0 immediately.
  - A write coinciding with reset assertion is lost.
  - On the first edge after rst deasserts, normal operation resumes.
- No X propagation: the register file is fully reset. Latency from in_* to architectural state is 1 clock; bypass latency is 0.

Test Plan:
- Reset, then read all addrs on both ports -> 0; out_flag=000, out_halted=0, out_commit_cnt=0.
- write_reg=1, dst=3, alu_out=16'hABCD, rd_addr1=3 in the same cycle -> out_rd_data1=ABCD combinationally; next cycle reg3 reads ABCD, cnt=1.
- Writeback select:
  - mem_to_reg=1, mem_data=16'h1234, dst=5 -> reg5=1234.
  - pcs=1 and mem_to_reg=1 with pc_nxt=16'h0042 -> reg5=0042.
- write_reg=1, dst=0, alu_out=FFFF -> R0 reads 0, out_wb_en=0, cnt unchanged.
- Flags:
  - flag=111, flag_en=001 -> out_flag=001.
  - Then flag=010, flag_en=110 -> out_flag=011.
  - out_flag_fwd shows the merged value in the same cycle.
- Halt:
  - in_halt=1 with dst=2 write of 0007 -> reg2=0007, out_halted=1.
  - Subsequent write dst=2 of 0008 and flag_en=111 -> ignored; cnt frozen.
  - rst mid-run -> everything clears asynchronously before the next edge.
